// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Handshake bundle between the PC sequencer and whatever drives and
//   consumes it: control requests, the jump target, the downstream ready,
//   and the registered PC offer.
//
// Parameters
//   N          PC width in bits
//
// Signals
//   start      leave IDLE/HALT and begin issuing
//   halt_req   stop issuing after the current cycle
//   load       parallel load request
//   load_val   jump target [N-1:0]
//   pc_ready   downstream accepts the current PC
//   pc         current program counter [N-1:0]
//   pc_valid   pc is offered downstream
//   wrap       one-cycle pulse when the PC rolls from all-ones to 0
//              (only when PC_WRAP_DETECT_EN is defined)
//
// Modports
//   master     the sequencer side (drives pc, pc_valid, wrap)
//   slave      the control/fetch side (drives the requests and pc_ready)

interface pc_sequencer_if #(
  parameter int N = 4
);

  logic         start;
  logic         halt_req;
  logic         load;
  logic [N-1:0] load_val;
  logic         pc_ready;
  logic [N-1:0] pc;
  logic         pc_valid;
`ifdef PC_WRAP_DETECT_EN
  logic         wrap;
`endif

`ifdef PC_WRAP_DETECT_EN
  modport master (
    input  start, halt_req, load, load_val, pc_ready,
    output pc, pc_valid, wrap
  );

  modport slave (
    output start, halt_req, load, load_val, pc_ready,
    input  pc, pc_valid, wrap
  );
`else
  modport master (
    input  start, halt_req, load, load_val, pc_ready,
    output pc, pc_valid
  );

  modport slave (
    output start, halt_req, load, load_val, pc_ready,
    input  pc, pc_valid
  );
`endif

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Registered program-counter stage. Each accepted handshake
//   (pc_valid & pc_ready) latches incrementor(pc) back into the PC register.
//   A three-state FSM (IDLE/RUN/HALT) gates the offer to the fetch stage,
//   and a parallel load path supports jumps in any state.
//
// Configuration macro
//   PC_WRAP_DETECT_EN  when defined, adds the registered 'wrap' pulse.
//
// Parameters
//   N          PC width in bits (also the incrementor width)
//   RESET_VAL  PC value after reset
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   bus        pc_sequencer_if master modport (requests in, pc/pc_valid/wrap out)

// incrementor: (a + 1) mod 2^N, no carry-out.
module incrementor #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = a + N'(1);

endmodule

module pc_sequencer #(
  parameter int           N         = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  pc_sequencer_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] pc_q;
  logic [N-1:0] pc_inc;
  logic         valid_q;
  logic         fire;

  incrementor #(.N(N)) u_inc (
    .a (pc_q),
    .y (pc_inc)
  );

  // Handshake completes only while the PC is actually offered.
  assign fire = valid_q & bus.pc_ready;

  // PC register: reset beats load, load beats the increment on fire, so a
  // jump issued together with a fire still consumes the current PC but
  // lands on load_val. Without fire or load the PC holds, which keeps it
  // stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (bus.load) begin
      pc_q <= bus.load_val;
    end else if (fire) begin
      pc_q <= pc_inc;
    end
  end

  // Control FSM with pc_valid registered alongside the state so the output
  // has no combinational path from the inputs. In RUN a simultaneous
  // start/halt_req halts; in IDLE/HALT start wins because halt_req is not
  // looked at there. A halt with fire still lets the PC advance above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.halt_req) begin
            state   <= HALT;
            valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (bus.start) begin
            state   <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = valid_q;

`ifdef PC_WRAP_DETECT_EN
  logic wrap_q;

  // Wrap pulse: the PC is about to roll from all-ones to 0 through the
  // incrementor. A load on the same edge redirects the PC, so no wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= fire & ~bus.load & (&pc_q);
    end
  end

  assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer (N=4, RESET_VAL=0). A table of
//   per-cycle vectors covers reset/step, wrap, backpressure, load-over-fire,
//   halt/resume, start/halt collisions and reset mid-run; hand-written
//   sequences then cover a long free run across the wrap and a halt with
//   fire. The wrap output is only checked when PC_WRAP_DETECT_EN is defined.

module tb_pc_sequencer;

  localparam int N = 4;

  logic clk;
  logic rst;

  int compared;
  int mismatched;

  pc_sequencer_if #(.N(N)) bus ();

  pc_sequencer #(
    .N         (N),
    .RESET_VAL (4'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         start;
    logic         halt_req;
    logic         load;
    logic [N-1:0] load_val;
    logic         pc_ready;
    logic [N-1:0] exp_pc;
    logic         exp_valid;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[$];

  // Build one table row: inputs for a cycle, outputs expected after its edge.
  function automatic vec_t mk(input logic r, input logic s, input logic h,
                              input logic l, input logic [N-1:0] lv,
                              input logic rdy, input logic [N-1:0] epc,
                              input logic ev, input logic ew);
    vec_t v;
    v.rst = r; v.start = s; v.halt_req = h; v.load = l; v.load_val = lv;
    v.pc_ready = rdy; v.exp_pc = epc; v.exp_valid = ev; v.exp_wrap = ew;
    return v;
  endfunction

  // Drive inputs away from the active edge, then step past one rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic h,
                               input logic l, input logic [N-1:0] lv,
                               input logic rdy);
    @(negedge clk);
    rst          = r;
    bus.start    = s;
    bus.halt_req = h;
    bus.load     = l;
    bus.load_val = lv;
    bus.pc_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] exp_pc,
                             input logic exp_valid, input logic exp_wrap);
    compared++;
    if (bus.pc !== exp_pc) begin
      mismatched++;
      $display("[TB] FAIL %s.pc: got %h expected %h", tag, bus.pc, exp_pc);
    end
    compared++;
    if (bus.pc_valid !== exp_valid) begin
      mismatched++;
      $display("[TB] FAIL %s.pc_valid: got %b expected %b", tag, bus.pc_valid, exp_valid);
    end
`ifdef PC_WRAP_DETECT_EN
    compared++;
    if (bus.wrap !== exp_wrap) begin
      mismatched++;
      $display("[TB] FAIL %s.wrap: got %b expected %b", tag, bus.wrap, exp_wrap);
    end
`else
    if (exp_wrap === 1'bx) $display("[TB] note: unknown wrap expectation in %s", tag);
`endif
  endtask

  initial begin
    logic [N-1:0] model_pc;
    logic         model_wrap;
    int           budget;

    compared   = 0;
    mismatched = 0;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.pc_ready = 1'b0;

    //            rst  st   hlt  ld   lval   rdy  | pc     v    w
    // Reset and step
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,4'h0,1'b0, 4'h0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,4'h0,1'b0, 4'h0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,4'h0,1'b1, 4'h0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h1,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h2,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h3,1'b1,1'b0));
    // Load beats fire at pc=3
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'hA,1'b1, 4'hA,1'b1,1'b0));
    // Wrap: E, F, 0 (wrap), 1
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'hE,1'b0, 4'hE,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'hF,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h1,1'b1,1'b0));
    // Backpressure at pc=5 for 3 cycles, then advance
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'h5,1'b0, 4'h5,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b0, 4'h5,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b0, 4'h5,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b0, 4'h5,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h6,1'b1,1'b0));
    // Halt with fire at pc=7, hold in HALT, resume, collisions
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'h7,1'b0, 4'h7,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,4'h0,1'b1, 4'h8,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h8,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h8,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,4'h0,1'b0, 4'h8,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h8,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h8,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h9,1'b1,1'b0));
    // Reset mid-run with load at pc=9
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'hC,1'b1, 4'h0,1'b0,1'b0));
    // Load in IDLE, start+halt in IDLE (start wins), step
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'h3,1'b1, 4'h3,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,4'h0,1'b1, 4'h3,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h4,1'b1,1'b0));
    // Load at all-ones with fire: redirected, no wrap
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'hF,1'b0, 4'hF,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,4'h2,1'b1, 4'h2,1'b1,1'b0));

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].halt_req,
                    vecs[i].load, vecs[i].load_val, vecs[i].pc_ready);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].exp_pc,
                  vecs[i].exp_valid, vecs[i].exp_wrap);
    end

    // Long free run from reset across the wrap, with a bounded start wait.
    $display("[TB] free run across wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("run_reset", 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    budget = 4;
    while (bus.pc_valid !== 1'b1 && budget > 0) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      budget--;
    end
    compared++;
    if (bus.pc_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL start_wait: got pc_valid=%b expected 1 within budget", bus.pc_valid);
    end
    checkOutput("run_start", 4'h0, 1'b1, 1'b0);
    model_pc = 4'h0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      model_wrap = (model_pc == 4'hF);
      model_pc   = model_pc + 4'h1;
      checkOutput($sformatf("run[%0d]", k), model_pc, 1'b1, model_wrap);
    end

    // Halt with fire: PC still advances, then holds with ready high.
    $display("[TB] halt with fire after free run");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    model_pc = model_pc + 4'h1;
    checkOutput("halt_fire", model_pc, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      checkOutput($sformatf("halt_hold[%0d]", k), model_pc, 1'b0, 1'b0);
    end
    // Load while halted changes PC but not state.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1);
    checkOutput("halt_load", 4'hB, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
